// File: rtl/adder_tree_seq_pkg.sv
// Shared types, defaults and elaboration helpers for adder_tree_sequencer.
//   tag_t          : per-stage {valid, last} marker that travels beside tree data
//   is_pow2_ge2()  : true when n is a power of two and at least 2
//   tree_out_w()   : result width of a NUM_INPUTS-wide adder tree
//   acc_fits()     : true when the accumulator can hold one full tree result
package adder_tree_seq_pkg;

  localparam int DEF_NUM_INPUTS = 8;
  localparam int DEF_INPUT_SIZE = 8;
  localparam int DEF_ACC_SIZE   = 32;
  localparam int DEF_BEAT_W     = 16;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  function automatic bit is_pow2_ge2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int tree_out_w(input int in_w, input int n);
    return in_w + $clog2(n);
  endfunction

  function automatic bit acc_fits(input int acc_w, input int in_w, input int n);
    return acc_w >= tree_out_w(in_w, n);
  endfunction

endpackage

// File: rtl/pipelined_adder_tree.sv
// Pipelined binary adder tree, one register level per tree stage.
//   clk      : clock
//   advance  : when 1 every stage register loads; when 0 all stages hold
//   in_data  : NUM_INPUTS unsigned elements, element 0 in the LSBs
//   out_sum  : sum of the elements presented $clog2(NUM_INPUTS) advances ago
// Data registers are intentionally unreset; the owner tracks validity.
module pipelined_adder_tree #(
  parameter int NUM_INPUTS  = 8,
  parameter int INPUT_SIZE  = 8,
  parameter int OUTPUT_SIZE = INPUT_SIZE + $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             advance,
  input  logic [NUM_INPUTS*INPUT_SIZE-1:0] in_data,
  output logic [OUTPUT_SIZE-1:0]           out_sum
);

  // Heap layout: node k adds nodes 2k and 2k+1. Indices NUM_INPUTS..2*NUM_INPUTS-1
  // are the (combinational) leaves, 1..NUM_INPUTS-1 are registers, 1 is the root.
  // Nodes NUM_INPUTS/2..NUM_INPUTS-1 form the first stage, node 1 the last.
  logic [OUTPUT_SIZE-1:0] node  [2*NUM_INPUTS-1:1];
  logic [OUTPUT_SIZE-1:0] sum_q [NUM_INPUTS-1:1];
  logic [OUTPUT_SIZE-1:0] sum_d [NUM_INPUTS-1:1];

  always_comb begin
    for (int k = 1; k < NUM_INPUTS; k++) begin
      node[k] = sum_q[k];
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      node[NUM_INPUTS+i] = OUTPUT_SIZE'(in_data[i*INPUT_SIZE +: INPUT_SIZE]);
    end
  end

  always_comb begin
    for (int k = 1; k < NUM_INPUTS; k++) begin
      sum_d[k] = advance ? (node[2*k] + node[2*k+1]) : sum_q[k];
    end
  end

  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

  assign out_sum = sum_q[1];

endmodule

// File: rtl/adder_tree_sequencer.sv
// Streams long unsigned vectors through one pipelined adder tree, NUM_INPUTS
// elements per beat, accumulates per-beat partial sums and emits one total
// per vector.
//   clk, rstn            : clock, asynchronous active-low reset
//   clear                : synchronous flush of tags, accumulator and result
//   in_valid/in_ready    : beat handshake; in_data packed, in_last marks end
//   out_valid/out_ready  : result handshake; out_sum total, out_beats count
//   busy                 : a beat is in the tree or a partial vector is held
//
// Handshake semantics (both ports): a transfer happens at a posedge where
// valid && ready. out_valid, once raised, holds with stable data until taken.
// in_ready is combinational from out_ready (in_ready = !(out_valid &&
// !out_ready)); integrators must not close a loop through it.
module adder_tree_sequencer
  import adder_tree_seq_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int ACC_SIZE   = DEF_ACC_SIZE,
  parameter int BEAT_W     = DEF_BEAT_W
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*INPUT_SIZE-1:0] in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_SIZE-1:0]              out_sum,
  output logic [BEAT_W-1:0]                out_beats,
  output logic                             busy
);

  localparam int NUM_STAGES = $clog2(NUM_INPUTS);
  localparam int TREE_W     = tree_out_w(INPUT_SIZE, NUM_INPUTS);

  if (!is_pow2_ge2(NUM_INPUTS)) begin : g_bad_num_inputs
    $error("adder_tree_sequencer: NUM_INPUTS must be a power of two >= 2");
  end
  if (!acc_fits(ACC_SIZE, INPUT_SIZE, NUM_INPUTS)) begin : g_bad_acc_size
    $error("adder_tree_sequencer: ACC_SIZE must be >= INPUT_SIZE+NUM_STAGES");
  end

  logic              stall;
  logic              advance;
  logic [TREE_W-1:0] tree_sum;
  logic [ACC_SIZE-1:0] tree_ext;
  tag_t              tail;

  tag_t                tag_q [NUM_STAGES];
  tag_t                tag_d [NUM_STAGES];
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [ACC_SIZE-1:0] out_sum_q, out_sum_d;
  logic [BEAT_W-1:0]   out_beats_q, out_beats_d;

  pipelined_adder_tree #(
    .NUM_INPUTS (NUM_INPUTS),
    .INPUT_SIZE (INPUT_SIZE),
    .OUTPUT_SIZE(TREE_W)
  ) u_tree (
    .clk    (clk),
    .advance(advance),
    .in_data(in_data),
    .out_sum(tree_sum)
  );

  // A held result blocks everything upstream so no beat is lost or repeated.
  assign stall    = out_valid_q && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;
  assign tree_ext = ACC_SIZE'(tree_sum);
  assign tail     = tag_q[NUM_STAGES-1];

  always_comb begin
    tag_d       = tag_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;

    if (clear) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        tag_d[s] = '0;
      end
      acc_d       = '0;
      beat_cnt_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (advance) begin
        for (int s = NUM_STAGES - 1; s > 0; s--) begin
          tag_d[s] = tag_q[s-1];
        end
        tag_d[0].valid = in_valid;
        tag_d[0].last  = in_last;
        if (tail.valid) begin
          if (tail.last) begin
            // Overrides the handshake clear above when a result is taken
            // and the next one lands on the same edge.
            out_sum_d   = acc_q + tree_ext;
            out_beats_d = beat_cnt_q + BEAT_W'(1);
            out_valid_d = 1'b1;
            acc_d       = '0;
            beat_cnt_d  = '0;
          end else begin
            acc_d      = acc_q + tree_ext;
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        tag_q[s] <= '0;
      end
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
    end else begin
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
    end
  end

  always_comb begin
    busy = (beat_cnt_q != '0);
    for (int s = 0; s < NUM_STAGES; s++) begin
      busy = busy | tag_q[s].valid;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;

endmodule
